// File: rtl/opsel_pkg.sv
// Shared types and chord-to-opcode table for the opcode chord latch.
package opsel_pkg;

  localparam int unsigned CHORD_W    = 4;
  localparam int unsigned NUM_CHORDS = 10;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_MOD = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_WAIT_REL = 2'd2,
    ST_DECODE   = 2'd3
  } state_e;

  typedef struct packed {
    logic [CHORD_W-1:0] chord;
    opcode_e            op;
  } chord_entry_t;

  typedef struct packed {
    logic    hit;
    opcode_e op;
  } lookup_t;

  localparam chord_entry_t CHORD_TABLE [NUM_CHORDS] = '{
    '{chord: 4'b0001, op: OP_ADD},
    '{chord: 4'b0010, op: OP_SUB},
    '{chord: 4'b0100, op: OP_MUL},
    '{chord: 4'b1000, op: OP_DIV},
    '{chord: 4'b0101, op: OP_MOD},
    '{chord: 4'b0011, op: OP_AND},
    '{chord: 4'b0110, op: OP_OR},
    '{chord: 4'b1100, op: OP_XOR},
    '{chord: 4'b0111, op: OP_SHL},
    '{chord: 4'b1110, op: OP_SHR}
  };

  // Chords absent from the table report hit=0; op is then don't-care (ADD).
  function automatic lookup_t chord_lookup(input logic [CHORD_W-1:0] chord);
    lookup_t r;
    r.hit = 1'b0;
    r.op  = OP_ADD;
    for (int i = 0; i < NUM_CHORDS; i++) begin
      if (CHORD_TABLE[i].chord == chord) begin
        r.hit = 1'b1;
        r.op  = CHORD_TABLE[i].op;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for one push-button.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             clean_q, clean_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Counter tracks consecutive cycles where the synced input disagrees with clean.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    clean_d = clean_q;
    cnt_d   = '0;
    if (sync2_q != clean_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        clean_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clean = clean_q;

endmodule

// File: rtl/opcode_chord_latch.sv
// Debounces four buttons, collects a chord over a window and latches the decoded ALU opcode.
// Define OPSEL_STICKY_ERROR_EN for a level op_error plus a saturating err_count output.
module opcode_chord_latch
  import opsel_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned OPCODE_W        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CHORD_WINDOW    = 250000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [OPCODE_W-1:0] opcode,
  output logic                op_valid,
  output logic                op_error,
  output logic                busy
`ifdef OPSEL_STICKY_ERROR_EN
  ,
  output logic [7:0]          err_count
`endif
);

  localparam int unsigned TIMER_W = $clog2(CHORD_WINDOW + 1);

  if (NUM_KEYS != 4) begin : g_bad_num_keys
    $error("opcode_chord_latch: chord table is defined for NUM_KEYS == 4 only");
  end
  if (OPCODE_W < 4) begin : g_bad_opcode_w
    $error("opcode_chord_latch: OPCODE_W must be at least 4");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("opcode_chord_latch: DEBOUNCE_CYCLES must be at least 2");
  end
  if (CHORD_WINDOW < 1) begin : g_bad_window
    $error("opcode_chord_latch: CHORD_WINDOW must be at least 1");
  end

  logic [NUM_KEYS-1:0] kd;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (key_raw[k]),
      .clean(kd[k])
    );
  end

  state_e              state_q,    state_d;
  logic [NUM_KEYS-1:0] acc_q,      acc_d;
  logic [TIMER_W-1:0]  timer_q,    timer_d;
  logic [OPCODE_W-1:0] opcode_q,   opcode_d;
  logic                op_valid_q, op_valid_d;
  logic                op_error_q, op_error_d;
  logic                busy_q,     busy_d;
  lookup_t             lk;
`ifdef OPSEL_STICKY_ERROR_EN
  logic [7:0]          err_count_q, err_count_d;
`endif

  assign lk = chord_lookup(CHORD_W'(acc_q));

  // Chord FSM; busy is registered from the next state so it tracks state_q != IDLE.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    timer_d    = timer_q;
    opcode_d   = opcode_q;
    op_valid_d = 1'b0;
`ifdef OPSEL_STICKY_ERROR_EN
    op_error_d  = op_error_q;
    err_count_d = err_count_q;
`else
    op_error_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (kd != '0) begin
          state_d = ST_COLLECT;
          acc_d   = kd;
          timer_d = '0;
        end
      end

      ST_COLLECT: begin
        acc_d   = acc_q | kd;
        timer_d = timer_q + TIMER_W'(1);
        if ((timer_q == TIMER_W'(CHORD_WINDOW - 1)) || (kd == '0)) begin
          state_d = ST_WAIT_REL;
        end
      end

      ST_WAIT_REL: begin
        if (kd == '0) begin
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        state_d = ST_IDLE;
        if (lk.hit) begin
          opcode_d   = OPCODE_W'(lk.op);
          op_valid_d = 1'b1;
          op_error_d = 1'b0;
        end else begin
          op_error_d = 1'b1;
`ifdef OPSEL_STICKY_ERROR_EN
          if (err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
          end
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      timer_q    <= '0;
      opcode_q   <= '0;
      op_valid_q <= 1'b0;
      op_error_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef OPSEL_STICKY_ERROR_EN
      err_count_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      timer_q    <= timer_d;
      opcode_q   <= opcode_d;
      op_valid_q <= op_valid_d;
      op_error_q <= op_error_d;
      busy_q     <= busy_d;
`ifdef OPSEL_STICKY_ERROR_EN
      err_count_q <= err_count_d;
`endif
    end
  end

  assign opcode   = opcode_q;
  assign op_valid = op_valid_q;
  assign op_error = op_error_q;
  assign busy     = busy_q;
`ifdef OPSEL_STICKY_ERROR_EN
  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_opcode_chord_latch.sv
// Scoreboard bench for opcode_chord_latch: directed chords plus randomized chords vs a table model.
module tb_opcode_chord_latch;

  localparam int unsigned DB = 4;
  localparam int unsigned CW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_raw = 4'd0;
  logic [3:0] opcode;
  logic       op_valid;
  logic       op_error;
  logic       busy;

  typedef struct {
    bit         is_err;
    logic [3:0] op;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         failures = 0;
  logic [3:0] model_op = 4'd0;
  logic [3:0] mon_op = 4'd0;
  bit         prev_pulse = 1'b0;

  opcode_chord_latch #(
    .NUM_KEYS       (4),
    .OPCODE_W       (4),
    .DEBOUNCE_CYCLES(DB),
    .CHORD_WINDOW   (CW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_raw (key_raw),
    .opcode  (opcode),
    .op_valid(op_valid),
    .op_error(op_error),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Reference chord table written directly from the opcode list.
  function automatic bit ref_lookup(input logic [3:0] c, output logic [3:0] op);
    bit hit;
    hit = 1'b1;
    case (c)
      4'b0001: op = 4'd0;
      4'b0010: op = 4'd1;
      4'b0100: op = 4'd2;
      4'b1000: op = 4'd3;
      4'b0101: op = 4'd4;
      4'b0011: op = 4'd5;
      4'b0110: op = 4'd6;
      4'b1100: op = 4'd7;
      4'b0111: op = 4'd8;
      4'b1110: op = 4'd9;
      default: begin
        op  = 4'd0;
        hit = 1'b0;
      end
    endcase
    return hit;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops the scoreboard on every pulse, otherwise checks opcode is held.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_op     = 4'd0;
      prev_pulse = 1'b0;
    end else begin
      if (op_valid || op_error) begin
        check("pulse_exclusive", 32'(op_valid & op_error), 32'd0);
        check("pulse_width", 32'(prev_pulse), 32'd0);
        check("busy_at_pulse", 32'(busy), 32'd0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse valid=%0b error=%0b expected no pulse at %0t",
                   op_valid, op_error, $time);
        end else begin
          mon_e = sb.pop_front();
          check("pulse_kind_error", 32'(op_error), 32'(mon_e.is_err));
          check("pulse_opcode", 32'(opcode), 32'(mon_e.op));
          mon_op = mon_e.op;
        end
      end else begin
        check("opcode_hold", 32'(opcode), 32'(mon_op));
      end
      prev_pulse = op_valid | op_error;
    end
  end

  task automatic drain(input string name);
    for (int i = 0; i < 80; i++) begin
      if (sb.size() == 0) break;
      step(1);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout pending=%0d expected 0", name, sb.size());
      sb.delete();
    end
    step(4);
    check({name, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  // Press 'first', add 'late' after 'stagger' cycles, hold, release all.
  // Late keys debounced inside the chord window are merged; well after it they are ignored.
  task automatic play(input string name, input logic [3:0] first, input logic [3:0] late,
                      input int stagger, input int hold);
    logic [3:0] chord;
    logic [3:0] op;
    bit         hit;
    exp_t       ne;
    chord = (stagger <= 3) ? (first | late) : first;
    hit = ref_lookup(chord, op);
    if (hit) model_op = op;
    ne.is_err = !hit;
    ne.op     = model_op;
    sb.push_back(ne);
    key_raw = first;
    step(stagger);
    key_raw = first | late;
    step(hold);
    check({name, "_busy_held"}, 32'(busy), 32'd1);
    key_raw = 4'd0;
    drain(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] f;
    logic [3:0] l;
    int         s;
    int         h;
    bit         seen;

    step(3);
    check("reset_opcode", 32'(opcode), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(op_valid), 32'd0);
    check("reset_error", 32'(op_error), 32'd0);
    rst_n = 1'b1;
    step(3);

    play("t1_add", 4'b0001, 4'b0000, 0, 20);
    play("t2_mod", 4'b0001, 4'b0100, 3, 15);
    play("t3_miss", 4'b1001, 4'b0000, 0, 20);
    check("t3_opcode_kept", 32'(opcode), 32'd4);

    // Short glitch never survives the debouncer.
    key_raw = 4'b0010;
    step(3);
    key_raw = 4'b0000;
    for (int i = 0; i < 15; i++) begin
      step(1);
      check("t4_glitch_busy", 32'(busy), 32'd0);
    end

    play("t5_late", 4'b0010, 4'b1000, 12, 15);
    check("t5_opcode_sub", 32'(opcode), 32'd1);

    play("t6_xor", 4'b1100, 4'b0000, 0, 15);
    key_raw = 4'b0001;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (busy) begin
        seen = 1'b1;
        break;
      end
    end
    check("t6_busy_before_reset", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_reset_opcode", 32'(opcode), 32'd0);
    check("t6_reset_busy", 32'(busy), 32'd0);
    sb.delete();
    model_op = 4'd0;
    key_raw = 4'd0;
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step(1);
      check("t6_post_reset_busy", 32'(busy), 32'd0);
    end

    for (int it = 0; it < 25; it++) begin
      f = 4'($urandom_range(1, 15));
      l = 4'($urandom_range(0, 15));
      s = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(12, 15));
      h = int'($urandom_range(10, 20));
      play("rand", f, l, s, h);
    end

    step(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
